piece_move_ctrl: RTL and testbench
==================================

Name: piece_move_ctrl

Overview:
- Sequencer for the falling tetromino: owns committed piece, pos_x, pos_y and rot.
- Time-shares the single combinational cell calculator between display and candidate checks: spawn, shift, rotate, gravity and hard drop.
- Validates each candidate against board bounds and board occupancy through a 1-bit board read port.
- Writes locked pieces into the board, hands off to the line-clear block, then spawns the next piece.

Parameters:
BOARD_W, 10, board width in cells (also drives block_wide to calculator)
BOARD_H, 20, board height in cells
SPAWN_X, 3, spawn column

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; leave IDLE/OVER and spawn
next_piece  in  3  piece id sampled at spawn
mv_left  in  1  pulse, shift left request
mv_right  in  1  pulse, shift right request
mv_rot  in  1  pulse, rotate (rot+1 mod 4) request
mv_drop  in  1  pulse, hard-drop request
tick  in  1  gravity pulse
calc_piece  out  3  to calculator piece input
calc_x  out  4  to calculator pos_x
calc_y  out  5  to calculator pos_y
calc_rot  out  2  to calculator rot
blk_1..blk_4  in  8 each  cell indices from calculator
width  in  3  from calculator
height  in  3  from calculator
blk_color  in  3  from calculator
rd_addr  out  8  board read address
rd_data  in  1  occupancy of rd_addr, valid one cycle after address
wr_en  out  1  board write strobe
wr_addr  out  8  board write address
wr_color  out  3  colour written
clr_start  out  1  one-cycle pulse to line-clear block
clr_done  in  1  line-clear completion pulse
busy  out  1  high in every state except READY, IDLE, OVER
game_over  out  1  high in OVER

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - piece/pos_x/pos_y/rot/rd_addr/wr_addr/wr_color = 0
  - wr_en, clr_start, busy, game_over = 0
  - gravity-pending flag and drop flag cleared
  - Reset mid-lock aborts remaining writes.
- States: IDLE, SPAWN, READY, CHECK, COMMIT, LOCK, CLEAR, OVER.
- calc_* outputs:
  - equal the candidate registers in SPAWN/CHECK;
  - equal the committed registers otherwise.
  - Candidate registers are stable for the whole check.
- IDLE/OVER: on start -> SPAWN.
- SPAWN: candidate = (next_piece, SPAWN_X, 0, 0) -> CHECK with origin=spawn.
- READY, one request per cycle, priority:
  1. gravity-pending or tick
  2. mv_rot
  3. mv_left
  4. mv_right
  5. mv_drop (sets drop flag, acts as down)
  - Down: candidate y=pos_y+1.
  - Left at pos_x=0: rejected in READY, no CHECK.
  - tick arriving while not READY sets gravity-pending (single bit; multiple ticks collapse). It is cleared when the down move is issued.
  - Buttons arriving while busy are dropped.
- CHECK, cycle 1:
  - Bounds check: fail if ({1'b0,cx}+width > BOARD_W) or ({1'b0,cy}+height > BOARD_H), using 6-bit arithmetic.
  - Bounds fail exits immediately, no board reads.
- CHECK, cycles 1..4: rd_addr=blk_k.
- CHECK, cycles 2..5: sample rd_data.
  - Any 1 = fail; a check is 5 cycles total.
- Check result:
  - Pass -> COMMIT: committed regs <= candidate. Values are visible the cycle after COMMIT, then READY.
    - If the drop flag is set, COMMIT instead re-issues a down candidate -> CHECK.
  - Fail, by move type:
    - Spawn -> OVER.
    - Down (gravity or drop) -> LOCK; drop flag cleared.
    - Shift/rotate -> READY, state unchanged.
- LOCK: 4 consecutive cycles with wr_en=1, wr_addr=blk_1..blk_4 of the committed piece, wr_color=blk_color -> CLEAR.
- CLEAR: clr_start=1 for exactly the first cycle. Wait for clr_done (may arrive any later cycle) -> SPAWN.
- Rotation wraps 3->0.
- No checks on pos_y underflow: up moves do not exist.

Test Plan:
1. Reset, start, next_piece=2 (O), empty board -> after 5-cycle check: piece=2, pos=(3,0), rot=0, busy=0; rd_addr walks 3, 4, 13, 14.
2. O at (3,0), mv_left in cycle 0 -> CHECK cycles 1–5, COMMIT cycle 6, pos_x=2 in cycle 7. With pos_x=0: no CHECK, pos unchanged, busy stays 0.
3. I piece (0) rot 0 at x=6, mv_right -> bounds fail (7+4>10) in CHECK cycle 1, back to READY cycle 2, pos_x=6.
4. O at (3,17), tick -> commit y=18. Second tick -> bounds fail -> LOCK writes 183, 184, 193, 194 with colour 3'b101. Then one clr_start pulse; after clr_done, spawn of next_piece.
5. mv_drop on empty board with O at (3,0) -> repeated checks to y=18, then lock at rows 18–19. A tick during drop sets pending and is serviced after the next spawn.
6. Board cell 4 occupied, start -> spawn check fails -> game_over=1, state OVER. Next start -> respawn attempt.
7. Assert rst_n low during LOCK after 2 writes -> wr_en=0 immediately, state IDLE, all outputs 0.

Source files
------------

// File: rtl/piece_move_ctrl.sv
// Falling-tetromino sequencer. It time-shares the external cell calculator between
// display and candidate checks, validates moves against the board and locks pieces in.
module piece_move_ctrl #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int SPAWN_X = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] next_piece,
    input  logic       mv_left,
    input  logic       mv_right,
    input  logic       mv_rot,
    input  logic       mv_drop,
    input  logic       tick,
    output logic [2:0] calc_piece,
    output logic [3:0] calc_x,
    output logic [4:0] calc_y,
    output logic [1:0] calc_rot,
    input  logic [7:0] blk_1,
    input  logic [7:0] blk_2,
    input  logic [7:0] blk_3,
    input  logic [7:0] blk_4,
    input  logic [2:0] width,
    input  logic [2:0] height,
    input  logic [2:0] blk_color,
    output logic [7:0] rd_addr,
    input  logic       rd_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [2:0] wr_color,
    output logic       clr_start,
    input  logic       clr_done,
    output logic       busy,
    output logic       game_over,
    output logic [2:0] dbg_state
);

    // Handshakes: start/mv_*/tick are single-cycle request pulses, honoured only in
    // the states that accept them; clr_start is a one-cycle pulse answered by a
    // one-cycle clr_done at any later cycle while waiting in CLEAR.
    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_READY, S_CHECK, S_COMMIT, S_LOCK, S_CLEAR, S_OVER
    } state_t;

    typedef enum logic [1:0] {ORG_SPAWN, ORG_DOWN, ORG_SHIFT} origin_t;

    typedef enum logic [2:0] {MV_NONE, MV_DOWN, MV_DROP, MV_ROT, MV_LEFT, MV_RIGHT} move_t;

    state_t     state, state_next, fail_state;
    origin_t    origin;
    move_t      move;
    logic [2:0] cnt;
    logic       hit, drop_flag, grav_pend;

    logic [2:0] piece, cand_piece;
    logic [3:0] pos_x, cand_x;
    logic [4:0] pos_y, cand_y;
    logic [1:0] rot, cand_rot;

    logic [5:0] x_end, y_end;
    logic       bounds_bad;
    logic [7:0] blk_sel;

    assign x_end      = {2'b00, cand_x} + {3'b000, width};
    assign y_end      = {1'b0, cand_y} + {3'b000, height};
    assign bounds_bad = (x_end > 6'(BOARD_W)) || (y_end > 6'(BOARD_H));

    always_comb begin
        blk_sel = blk_1;
        case (cnt[1:0])
            2'd0: blk_sel = blk_1;
            2'd1: blk_sel = blk_2;
            2'd2: blk_sel = blk_3;
            2'd3: blk_sel = blk_4;
            default: blk_sel = blk_1;
        endcase
    end

    always_comb begin
        fail_state = S_READY;
        case (origin)
            ORG_SPAWN: fail_state = S_OVER;
            ORG_DOWN:  fail_state = S_LOCK;
            default:   fail_state = S_READY;
        endcase
    end

    always_comb begin
        state_next = state;
        move       = MV_NONE;
        case (state)
            S_IDLE, S_OVER: if (start) state_next = S_SPAWN;
            S_SPAWN: state_next = S_CHECK;
            S_READY: begin
                if (grav_pend || tick)  move = MV_DOWN;
                else if (mv_rot)        move = MV_ROT;
                else if (mv_left)       move = (pos_x != 4'd0) ? MV_LEFT : MV_NONE;
                else if (mv_right)      move = MV_RIGHT;
                else if (mv_drop)       move = MV_DROP;
                if (move != MV_NONE) state_next = S_CHECK;
            end
            S_CHECK: begin
                // Cycle 1 bounds; the last board read returns on cycle 5.
                if (cnt == 3'd0 && bounds_bad)
                    state_next = fail_state;
                else if (cnt == 3'd4)
                    state_next = (hit || rd_data) ? fail_state : S_COMMIT;
            end
            S_COMMIT: state_next = drop_flag ? S_CHECK : S_READY;
            S_LOCK:   if (cnt == 3'd3) state_next = S_CLEAR;
            S_CLEAR:  if (clr_done) state_next = S_SPAWN;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hit        <= 1'b0;
            drop_flag  <= 1'b0;
            grav_pend  <= 1'b0;
            origin     <= ORG_SPAWN;
            piece      <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
            rot        <= '0;
            cand_piece <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            cand_rot   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if (cnt != 3'd7)
                cnt <= cnt + 3'd1;

            if (tick && state != S_READY)
                grav_pend <= 1'b1;

            case (state)
                S_SPAWN: begin
                    cand_piece <= next_piece;
                    cand_x     <= 4'(SPAWN_X);
                    cand_y     <= '0;
                    cand_rot   <= '0;
                    origin     <= ORG_SPAWN;
                end
                S_READY: begin
                    if (move != MV_NONE) begin
                        cand_piece <= piece;
                        cand_x     <= pos_x;
                        cand_y     <= pos_y;
                        cand_rot   <= rot;
                        origin     <= ORG_SHIFT;
                    end
                    case (move)
                        MV_DOWN: begin
                            cand_y    <= pos_y + 5'd1;
                            origin    <= ORG_DOWN;
                            grav_pend <= 1'b0;
                        end
                        MV_DROP: begin
                            cand_y    <= pos_y + 5'd1;
                            origin    <= ORG_DOWN;
                            drop_flag <= 1'b1;
                        end
                        MV_ROT:   cand_rot <= rot + 2'd1;
                        MV_LEFT:  cand_x   <= pos_x - 4'd1;
                        MV_RIGHT: cand_x   <= pos_x + 4'd1;
                        default: ;
                    endcase
                end
                S_CHECK: begin
                    hit <= (cnt == 3'd0) ? 1'b0 : (hit | rd_data);
                    if (state_next == S_LOCK)
                        drop_flag <= 1'b0;
                end
                S_COMMIT: begin
                    piece <= cand_piece;
                    pos_x <= cand_x;
                    pos_y <= cand_y;
                    rot   <= cand_rot;
                    // A hard drop keeps falling from the row just committed.
                    if (drop_flag)
                        cand_y <= cand_y + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        calc_piece = piece;
        calc_x     = pos_x;
        calc_y     = pos_y;
        calc_rot   = rot;
        if (state == S_SPAWN || state == S_CHECK) begin
            calc_piece = cand_piece;
            calc_x     = cand_x;
            calc_y     = cand_y;
            calc_rot   = cand_rot;
        end
        rd_addr = '0;
        if (state == S_CHECK && cnt < 3'd4 && !(cnt == 3'd0 && bounds_bad))
            rd_addr = blk_sel;
        wr_en     = (state == S_LOCK);
        wr_addr   = wr_en ? blk_sel : 8'd0;
        wr_color  = wr_en ? blk_color : 3'd0;
        clr_start = (state == S_CLEAR) && (cnt == 3'd0);
        busy      = !(state inside {S_READY, S_IDLE, S_OVER});
        game_over = (state == S_OVER);
        dbg_state = state;
    end

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed bench for piece_move_ctrl with a small I/O-piece cell calculator and a
// 1-bit registered board model.
module tb_piece_move_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_SPAWN = 3'd1, ST_READY = 3'd2, ST_CHECK = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4, ST_LOCK = 3'd5, ST_CLEAR = 3'd6, ST_OVER = 3'd7;

    logic       clk, rst_n, start, mv_left, mv_right, mv_rot, mv_drop, tick, clr_done;
    logic [2:0] next_piece, calc_piece, width, height, blk_color, wr_color, dbg_state;
    logic [3:0] calc_x;
    logic [4:0] calc_y;
    logic [1:0] calc_rot;
    logic [7:0] blk_1, blk_2, blk_3, blk_4, rd_addr, wr_addr, base;
    logic       rd_data, wr_en, clr_start, busy, game_over;

    logic       board [0:255];
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];
    int checks = 0;
    int errors = 0;

    piece_move_ctrl #(.BOARD_W(10), .BOARD_H(20), .SPAWN_X(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .next_piece(next_piece),
        .mv_left(mv_left), .mv_right(mv_right), .mv_rot(mv_rot), .mv_drop(mv_drop),
        .tick(tick), .calc_piece(calc_piece), .calc_x(calc_x), .calc_y(calc_y),
        .calc_rot(calc_rot), .blk_1(blk_1), .blk_2(blk_2), .blk_3(blk_3), .blk_4(blk_4),
        .width(width), .height(height), .blk_color(blk_color), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_color(wr_color),
        .clr_start(clr_start), .clr_done(clr_done), .busy(busy), .game_over(game_over),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // Cell calculator: piece 0 = I (horizontal for even rot), others = O (2x2).
    always_comb begin
        base      = 8'(int'(calc_y) * 10 + int'(calc_x));
        blk_color = (calc_piece == 3'd2) ? 3'b101 : 3'b001;
        width     = 3'd2;
        height    = 3'd2;
        blk_1     = base;
        blk_2     = base + 8'd1;
        blk_3     = base + 8'd10;
        blk_4     = base + 8'd11;
        if (calc_piece == 3'd0 && !calc_rot[0]) begin
            width = 3'd4; height = 3'd1;
            blk_2 = base + 8'd1; blk_3 = base + 8'd2; blk_4 = base + 8'd3;
        end else if (calc_piece == 3'd0) begin
            width = 3'd1; height = 3'd4;
            blk_2 = base + 8'd10; blk_3 = base + 8'd20; blk_4 = base + 8'd30;
        end
    end

    always @(posedge clk) rd_data <= board[rd_addr];

    always @(negedge clk) if (wr_en) got_q.push_back({wr_color, wr_addr});

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int which);
        case (which)
            0: mv_left = 1'b1;
            1: mv_right = 1'b1;
            2: mv_rot = 1'b1;
            3: mv_drop = 1'b1;
            4: tick = 1'b1;
            5: start = 1'b1;
            6: clr_done = 1'b1;
            default: begin mv_rot = 1'b1; mv_left = 1'b1; end
        endcase
        step(1);
        {mv_left, mv_right, mv_rot, mv_drop, tick, start, clr_done} = '0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (dbg_state == s) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 256; i++) board[i] = 1'b0;
    endtask

    task automatic do_reset();
        {mv_left, mv_right, mv_rot, mv_drop, tick, start, clr_done} = '0;
        next_piece = 3'd0;
        clear_board();
        got_q.delete();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic spawn_piece(input logic [2:0] p, input string nm);
        bit ok;
        next_piece = p;
        press(5);
        wait_state(ST_READY, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_ready: state %0d, required %0d", nm, dbg_state, ST_READY); end
    endtask

    task automatic test_reset();
        {mv_left, mv_right, mv_rot, mv_drop, tick, start, clr_done} = '0;
        next_piece = 3'd0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({dbg_state, busy, game_over, wr_en, clr_start} !== {ST_IDLE, 4'b0000}) begin
            errors++;
            $display("FAIL reset_ctrl: state/busy/over/wr/clr=%b, required %b", {dbg_state, busy, game_over, wr_en, clr_start}, {ST_IDLE, 4'b0000});
        end
        checks++;
        if ({calc_piece, calc_x, calc_y, calc_rot, rd_addr, wr_addr, wr_color} !== 33'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0", {calc_piece, calc_x, calc_y, calc_rot, rd_addr, wr_addr, wr_color});
        end
        step(2);
        rst_n = 1'b1;
        step(3);
        checks++;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL idle_hold: state %0d, required %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_spawn();
        logic [7:0] exp_rd [4];
        exp_rd = '{8'd3, 8'd4, 8'd13, 8'd14};
        next_piece = 3'd2;
        press(5);
        step(1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_addr !== exp_rd[k]) begin errors++; $display("FAIL spawn_rd_%0d: rd_addr %0d, required %0d", k, rd_addr, exp_rd[k]); end
            step(1);
        end
        step(2);
        checks++;
        if ({dbg_state, busy} !== {ST_READY, 1'b0}) begin
            errors++; $display("FAIL spawn_state: state/busy %b, required %b", {dbg_state, busy}, {ST_READY, 1'b0});
        end
        checks++;
        if ({calc_piece, calc_x, calc_y, calc_rot} !== {3'd2, 4'd3, 5'd0, 2'd0}) begin
            errors++; $display("FAIL spawn_pos: got %h, required %h", {calc_piece, calc_x, calc_y, calc_rot}, {3'd2, 4'd3, 5'd0, 2'd0});
        end
    endtask

    task automatic test_shift();
        press(0);
        checks++;
        if (dbg_state !== ST_CHECK) begin errors++; $display("FAIL left_check: state %0d, required %0d", dbg_state, ST_CHECK); end
        step(5);
        checks++;
        if ({dbg_state, calc_x} !== {ST_COMMIT, 4'd3}) begin
            errors++; $display("FAIL left_commit: state/x %h, required %h", {dbg_state, calc_x}, {ST_COMMIT, 4'd3});
        end
        step(1);
        checks++;
        if ({dbg_state, calc_x} !== {ST_READY, 4'd2}) begin
            errors++; $display("FAIL left_done: state/x %h, required %h", {dbg_state, calc_x}, {ST_READY, 4'd2});
        end
        for (int i = 0; i < 2; i++) begin press(0); step(6); end
        press(0);
        checks++;
        if ({dbg_state, busy, calc_x} !== {ST_READY, 1'b0, 4'd0}) begin
            errors++; $display("FAIL left_edge: state/busy/x %h, required %h", {dbg_state, busy, calc_x}, {ST_READY, 1'b0, 4'd0});
        end
        press(1);
        step(6);
        checks++;
        if (calc_x !== 4'd1) begin errors++; $display("FAIL right_from_edge: x %0d, required 1", calc_x); end
    endtask

    task automatic test_bounds_rotate();
        do_reset();
        spawn_piece(3'd0, "ipiece");
        for (int i = 0; i < 3; i++) begin press(1); step(6); end
        checks++;
        if (calc_x !== 4'd6) begin errors++; $display("FAIL i_at_6: x %0d, required 6", calc_x); end
        press(1);
        checks++;
        if ({dbg_state, calc_x} !== {ST_CHECK, 4'd7}) begin
            errors++; $display("FAIL bound_cand: state/x %h, required %h", {dbg_state, calc_x}, {ST_CHECK, 4'd7});
        end
        step(1);
        checks++;
        if ({dbg_state, calc_x, calc_rot} !== {ST_READY, 4'd6, 2'd0}) begin
            errors++; $display("FAIL bound_reject: state/x/rot %h, required %h", {dbg_state, calc_x, calc_rot}, {ST_READY, 4'd6, 2'd0});
        end
        press(7);
        step(6);
        checks++;
        if ({calc_x, calc_rot} !== {4'd6, 2'd1}) begin
            errors++; $display("FAIL rot_priority: x/rot %h, required %h", {calc_x, calc_rot}, {4'd6, 2'd1});
        end
        for (int i = 0; i < 3; i++) begin press(2); step(6); end
        checks++;
        if (calc_rot !== 2'd0) begin errors++; $display("FAIL rot_wrap: rot %0d, required 0", calc_rot); end
    endtask

    task automatic test_gravity_lock();
        logic [10:0] got;
        bit ok;
        do_reset();
        spawn_piece(3'd2, "grav");
        for (int i = 0; i < 18; i++) begin press(4); step(6); end
        checks++;
        if (calc_y !== 5'd18) begin errors++; $display("FAIL grav_y18: y %0d, required 18", calc_y); end
        exp_q.delete();
        exp_q.push_back({3'b101, 8'd183});
        exp_q.push_back({3'b101, 8'd184});
        exp_q.push_back({3'b101, 8'd193});
        exp_q.push_back({3'b101, 8'd194});
        got_q.delete();
        next_piece = 3'd0;
        press(4);
        step(1);
        checks++;
        if ({dbg_state, wr_en} !== {ST_LOCK, 1'b1}) begin
            errors++; $display("FAIL lock_enter: state/wr_en %b, required %b", {dbg_state, wr_en}, {ST_LOCK, 1'b1});
        end
        step(4);
        checks++;
        if ({dbg_state, clr_start, wr_en} !== {ST_CLEAR, 1'b1, 1'b0}) begin
            errors++; $display("FAIL clr_pulse: state/clr/wr %b, required %b", {dbg_state, clr_start, wr_en}, {ST_CLEAR, 2'b10});
        end
        step(1);
        checks++;
        if ({dbg_state, clr_start, busy} !== {ST_CLEAR, 1'b0, 1'b1}) begin
            errors++; $display("FAIL clr_once: state/clr/busy %b, required %b", {dbg_state, clr_start, busy}, {ST_CLEAR, 2'b01});
        end
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL lock_count: %0d writes, required 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < got_q.size()) ? got_q[i] : 11'h7ff;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL lock_wr_%0d: got %h, required %h", i, got, exp_q[i]); end
        end
        step(3);
        press(6);
        checks++;
        if (dbg_state !== ST_SPAWN) begin errors++; $display("FAIL clr_done_spawn: state %0d, required %0d", dbg_state, ST_SPAWN); end
        wait_state(ST_READY, 20, ok);
        checks++;
        if (!ok || {calc_piece, calc_x, calc_y} !== {3'd0, 4'd3, 5'd0}) begin
            errors++; $display("FAIL respawn: piece/x/y %h, required %h", {calc_piece, calc_x, calc_y}, {3'd0, 4'd3, 5'd0});
        end
    endtask

    task automatic test_drop();
        logic [10:0] got;
        bit ok;
        do_reset();
        spawn_piece(3'd2, "drop");
        got_q.delete();
        press(3);
        step(10);
        press(4);
        wait_state(ST_LOCK, 400, ok);
        checks++;
        if (!ok || calc_y !== 5'd18) begin errors++; $display("FAIL drop_lock: ok %0d y %0d, required 1 and 18", ok, calc_y); end
        wait_state(ST_CLEAR, 10, ok);
        checks++;
        if (!ok || got_q.size() != 4) begin errors++; $display("FAIL drop_count: %0d writes, required 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < got_q.size()) ? got_q[i] : 11'h7ff;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL drop_wr_%0d: got %h, required %h", i, got, exp_q[i]); end
        end
        next_piece = 3'd2;
        press(6);
        wait_state(ST_READY, 20, ok);
        checks++;
        if (!ok || calc_y !== 5'd0) begin errors++; $display("FAIL drop_respawn: ok %0d y %0d, required 1 and 0", ok, calc_y); end
        step(1);
        checks++;
        if ({dbg_state, calc_y} !== {ST_CHECK, 5'd1}) begin
            errors++; $display("FAIL pending_tick: state/y %h, required %h", {dbg_state, calc_y}, {ST_CHECK, 5'd1});
        end
        wait_state(ST_READY, 20, ok);
        checks++;
        if (!ok || calc_y !== 5'd1) begin errors++; $display("FAIL pending_done: ok %0d y %0d, required 1 and 1", ok, calc_y); end
    endtask

    task automatic test_game_over();
        bit ok;
        do_reset();
        board[4] = 1'b1;
        next_piece = 3'd2;
        press(5);
        wait_state(ST_OVER, 20, ok);
        checks++;
        if (!ok || {game_over, busy, calc_x} !== {1'b1, 1'b0, 4'd0}) begin
            errors++; $display("FAIL over: ok %0d over/busy/x %b, required 1 and %b", ok, {game_over, busy, calc_x}, {2'b10, 4'd0});
        end
        board[4] = 1'b0;
        press(5);
        checks++;
        if (dbg_state !== ST_SPAWN) begin errors++; $display("FAIL over_restart: state %0d, required %0d", dbg_state, ST_SPAWN); end
        wait_state(ST_READY, 20, ok);
        checks++;
        if (!ok || {game_over, calc_piece, calc_x} !== {1'b0, 3'd2, 4'd3}) begin
            errors++; $display("FAIL over_respawn: over/piece/x %h, required %h", {game_over, calc_piece, calc_x}, {1'b0, 3'd2, 4'd3});
        end
    endtask

    task automatic test_reset_mid_lock();
        bit ok;
        do_reset();
        spawn_piece(3'd2, "midlock");
        got_q.delete();
        press(3);
        wait_state(ST_LOCK, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midlock_reach: state %0d, required %0d", dbg_state, ST_LOCK); end
        step(2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dbg_state, wr_en, busy, game_over, clr_start} !== {ST_IDLE, 4'b0000}) begin
            errors++; $display("FAIL midlock_ctrl: got %b, required %b", {dbg_state, wr_en, busy, game_over, clr_start}, {ST_IDLE, 4'b0000});
        end
        checks++;
        if ({calc_piece, calc_x, calc_y, calc_rot, rd_addr, wr_addr, wr_color} !== 33'd0) begin
            errors++; $display("FAIL midlock_data: got %h, required 0", {calc_piece, calc_x, calc_y, calc_rot, rd_addr, wr_addr, wr_color});
        end
        step(2);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {3'b101, 8'd183} || got_q[1] !== {3'b101, 8'd184}) begin
            errors++; $display("FAIL midlock_writes: %0d writes, required 2 (183,184)", got_q.size());
        end
        rst_n = 1'b1;
        step(1);
        checks++;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midlock_idle: state %0d, required %0d", dbg_state, ST_IDLE); end
    endtask

    initial begin
        clear_board();
        test_reset();
        test_spawn();
        test_shift();
        test_bounds_rotate();
        test_gravity_lock();
        test_drop();
        test_game_over();
        test_reset_mid_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
